// File: rtl/tdc_decode_if.sv
// tdc_decode_if: start/tap-vector request and result bus of the TDC thermometer decoder.
// master = tap-register side (drives go/wDecodeIn), slave = decoder.
interface tdc_decode_if #(
    parameter int unsigned NUM_TAPS   = 300,
    parameter int unsigned NUM_DECODE = 10
);

    logic                  go;
    logic [NUM_TAPS-1:0]   wDecodeIn;
    logic                  finished;
    logic [NUM_DECODE-1:0] wDecodeOut;

    modport master (
        output go,
        output wDecodeIn,
        input  finished,
        input  wDecodeOut
    );

    modport slave (
        input  go,
        input  wDecodeIn,
        output finished,
        output wDecodeOut
    );

endinterface : tdc_decode_if

// File: rtl/tdc_decode.sv
// tdc_decode: thermometer-to-binary decoder for the tapped-delay-line TDC.
// Snapshots the tap vector on a start request and accumulates a bubble-tolerant
// population count CHUNK taps per cycle, then presents the result with a
// one-cycle finished strobe.
// Optional macro TDC_DECODE_GO_EDGE_EN: when defined, go is rising-edge
// detected (a held go starts exactly one conversion); otherwise go is
// level-sensitive.
module tdc_decode #(
    parameter int unsigned NUM_TAPS   = 300,
    parameter int unsigned NUM_DECODE = 10,
    parameter int unsigned CHUNK      = 6,
    parameter bit          falling    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    tdc_decode_if.slave bus
);

    // Derived sizes
    localparam int unsigned NUM_CHUNKS = (NUM_TAPS + CHUNK - 1) / CHUNK;
    localparam int unsigned PAD_W      = NUM_CHUNKS * CHUNK;
    localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int unsigned CNT_W      = $clog2(CHUNK + 1);
    localparam int unsigned LAST_IDX   = NUM_CHUNKS - 1;

    // Elaboration-time sanity checks on the configuration
    generate
        if ((64'd1 << NUM_DECODE) <= 64'(NUM_TAPS)) begin : g_bad_decode_w
            $error("tdc_decode: NUM_DECODE too narrow for NUM_TAPS");
        end
        if (CHUNK == 0) begin : g_bad_chunk
            $error("tdc_decode: CHUNK must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [NUM_TAPS-1:0]   r_snap;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_DECODE-1:0] r_acc;
    logic                  r_finished;
    logic [NUM_DECODE-1:0] r_out;

    logic                  w_start;
    logic                  w_load;
    logic                  w_add;
    logic                  w_done;
    logic                  w_last;
    logic [NUM_TAPS-1:0]   w_marked;
    logic [PAD_W-1:0]      w_marked_pad;
    logic [CHUNK-1:0]      w_chunk;
    logic [CNT_W-1:0]      w_pop;

`ifdef TDC_DECODE_GO_EDGE_EN
    logic                  r_go_d;

    // Registered copy of go for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_go_d <= 1'b0;
        end else begin
            r_go_d <= bus.go;
        end
    end

    assign w_start = bus.go & ~r_go_d;
`else
    assign w_start = bus.go;
`endif

    assign w_last = (r_idx == IDX_W'(LAST_IDX));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control; go outside IDLE is dropped
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_add       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_COUNT;
                end
            end
            S_COUNT: begin
                w_add = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Counted bits are ones for a rising edge, zeros for a falling edge;
    // zero padding past NUM_TAPS keeps the short last chunk from counting
    // bits that do not exist.
    assign w_marked     = falling ? ~r_snap : r_snap;
    assign w_marked_pad = PAD_W'(w_marked);

    // Select the chunk addressed by the running index
    always_comb begin
        w_chunk = '0;
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            if (r_idx == IDX_W'(c)) begin
                w_chunk = w_marked_pad[c*CHUNK +: CHUNK];
            end
        end
    end

    // Population count of the selected chunk
    always_comb begin
        w_pop = '0;
        for (int b = 0; b < CHUNK; b++) begin
            w_pop = w_pop + CNT_W'(w_chunk[b]);
        end
    end

    // Snapshot, chunk index and accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snap <= '0;
            r_idx  <= '0;
            r_acc  <= '0;
        end else if (w_load) begin
            r_snap <= bus.wDecodeIn;
            r_idx  <= '0;
            r_acc  <= '0;
        end else if (w_add) begin
            r_acc  <= r_acc + NUM_DECODE'(w_pop);
            r_idx  <= r_idx + IDX_W'(1);
        end
    end

    // Registered result and one-cycle strobe; result holds until the next DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_finished <= 1'b0;
            r_out      <= '0;
        end else begin
            r_finished <= w_done;
            if (w_done) begin
                r_out <= r_acc;
            end
        end
    end

    assign bus.finished   = r_finished;
    assign bus.wDecodeOut = r_out;

endmodule : tdc_decode

// File: tb/tb_tdc_decode.sv
// tb_tdc_decode: scoreboard bench for tdc_decode. Two instances (rising and
// falling polarity) share one stimulus stream; a reference model predicts each
// conversion's value and completion cycle, a monitor checks the outputs.
// Honours TDC_DECODE_GO_EDGE_EN to select the go start rule in the model.
module tb_tdc_decode;

    localparam int unsigned NUM_TAPS   = 300;
    localparam int unsigned NUM_DECODE = 10;
    localparam int unsigned CHUNK      = 6;
    localparam int unsigned NUM_CHUNKS = (NUM_TAPS + CHUNK - 1) / CHUNK;
    // finished is seen after edge go_edge + LAT (go-sampling edge counted as edge 1 -> edge N+2)
    localparam int unsigned LAT        = NUM_CHUNKS + 1;
    // earliest next start relative to a start edge
    localparam int unsigned BUSY       = NUM_CHUNKS + 2;
`ifdef TDC_DECODE_GO_EDGE_EN
    localparam int unsigned HOLD_PULSES = 1;
`else
    localparam int unsigned HOLD_PULSES = 2;
`endif

    typedef struct {
        int unsigned value;
        longint      cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                go_s = 1'b0;
    logic [NUM_TAPS-1:0] vec_s = '0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    longint      cyc = 0;
    longint      next_free = 0;
    bit          go_prev = 1'b0;
    exp_t        q_r[$];
    exp_t        q_f[$];
    int unsigned last_r = 0;
    int unsigned last_f = 0;
    int unsigned n_fin_r = 0;
    int unsigned n_fin_f = 0;

    always #5 clk = ~clk;

    tdc_decode_if #(.NUM_TAPS(NUM_TAPS), .NUM_DECODE(NUM_DECODE)) bus_r ();
    tdc_decode_if #(.NUM_TAPS(NUM_TAPS), .NUM_DECODE(NUM_DECODE)) bus_f ();

    assign bus_r.go        = go_s;
    assign bus_r.wDecodeIn = vec_s;
    assign bus_f.go        = go_s;
    assign bus_f.wDecodeIn = vec_s;

    tdc_decode #(
        .NUM_TAPS(NUM_TAPS), .NUM_DECODE(NUM_DECODE), .CHUNK(CHUNK), .falling(1'b0)
    ) dut_r (
        .clk(clk), .rst(rst), .bus(bus_r.slave)
    );

    tdc_decode #(
        .NUM_TAPS(NUM_TAPS), .NUM_DECODE(NUM_DECODE), .CHUNK(CHUNK), .falling(1'b1)
    ) dut_f (
        .clk(clk), .rst(rst), .bus(bus_f.slave)
    );

    // Reference count: plain bit-by-bit tally over the whole vector
    function automatic int unsigned ref_count(input logic [NUM_TAPS-1:0] v, input bit count_zeros);
        int unsigned n = 0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (v[i] != count_zeros) n++;
        end
        return n;
    endfunction

    // Model: decides which edges start a conversion and queues the expected results
    initial begin
        bit   start;
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                q_r.delete();
                q_f.delete();
                next_free = cyc + 1;
                go_prev   = 1'b0;
            end else begin
`ifdef TDC_DECODE_GO_EDGE_EN
                start = go_s && !go_prev && (cyc >= next_free);
`else
                start = go_s && (cyc >= next_free);
`endif
                if (start) begin
                    e.cyc   = cyc + longint'(LAT);
                    e.value = ref_count(vec_s, 1'b0);
                    q_r.push_back(e);
                    e.value = ref_count(vec_s, 1'b1);
                    q_f.push_back(e);
                    next_free = cyc + longint'(BUSY);
                end
                go_prev = go_s;
            end
        end
    end

    // Monitor: pops on each finished strobe, otherwise checks the result is held
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                n_vec++;
                if (bus_r.finished) begin
                    n_fin_r++;
                    if (q_r.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_finished_r cyc=%0d got=%0d expected no result", cyc, bus_r.wDecodeOut);
                    end else begin
                        e = q_r.pop_front();
                        if (int'(bus_r.wDecodeOut) != int'(e.value) || cyc != e.cyc) begin
                            n_err++;
                            $display("FAIL result_r got=%0d@%0d expected=%0d@%0d", bus_r.wDecodeOut, cyc, e.value, e.cyc);
                        end
                        last_r = e.value;
                    end
                end else if (int'(bus_r.wDecodeOut) != int'(last_r)) begin
                    n_err++;
                    $display("FAIL hold_r cyc=%0d got=%0d expected=%0d", cyc, bus_r.wDecodeOut, last_r);
                end
                n_vec++;
                if (bus_f.finished) begin
                    n_fin_f++;
                    if (q_f.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_finished_f cyc=%0d got=%0d expected no result", cyc, bus_f.wDecodeOut);
                    end else begin
                        e = q_f.pop_front();
                        if (int'(bus_f.wDecodeOut) != int'(e.value) || cyc != e.cyc) begin
                            n_err++;
                            $display("FAIL result_f got=%0d@%0d expected=%0d@%0d", bus_f.wDecodeOut, cyc, e.value, e.cyc);
                        end
                        last_f = e.value;
                    end
                end else if (int'(bus_f.wDecodeOut) != int'(last_f)) begin
                    n_err++;
                    $display("FAIL hold_f cyc=%0d got=%0d expected=%0d", cyc, bus_f.wDecodeOut, last_f);
                end
            end
        end
    end

    task automatic check_val(input string name, input int unsigned got, input int unsigned want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    // Asynchronous reset away from the clock edge; outputs must clear at once
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst  = 1'b0;
        go_s = 1'b0;
        #1;
        last_r = 0;
        last_f = 0;
        check_val("reset_finished_r", 32'(bus_r.finished), 0);
        check_val("reset_out_r", 32'(bus_r.wDecodeOut), 0);
        check_val("reset_finished_f", 32'(bus_f.finished), 0);
        check_val("reset_out_f", 32'(bus_f.wDecodeOut), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic pulse_go(input logic [NUM_TAPS-1:0] v);
        @(posedge clk);
        #1;
        vec_s = v;
        go_s  = 1'b1;
        @(posedge clk);
        #1;
        go_s = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (bus_r.finished) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout_finished got=none expected=strobe within 200 cycles");
        end
    endtask

    task automatic run(input logic [NUM_TAPS-1:0] v);
        pulse_go(v);
        wait_done();
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    initial begin
        logic [NUM_TAPS-1:0] v;
        logic [NUM_TAPS-1:0] v2;
        int unsigned         t;
        int unsigned         fr0;

        // Reset state
        #2;
        check_val("init_finished_r", 32'(bus_r.finished), 0);
        check_val("init_out_r", 32'(bus_r.wDecodeOut), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // 37 low taps set
        v = '0;
        for (int i = 0; i < 37; i++) v[i] = 1'b1;
        run(v);

        // Top 5 taps set
        v = '0;
        for (int i = NUM_TAPS - 5; i < NUM_TAPS; i++) v[i] = 1'b1;
        run(v);

        // Extremes and last chunk
        v = '0;
        run(v);
        v = '1;
        run(v);
        v = '0;
        v[NUM_TAPS-1] = 1'b1;
        run(v);

        // Bubble: [9:0] plus bit 12
        v = '0;
        for (int i = 0; i < 10; i++) v[i] = 1'b1;
        v[12] = 1'b1;
        run(v);

        // Ones shifted in from the MSB, k = 1..NUM_TAPS
        v = '0;
        for (int k = 1; k <= NUM_TAPS; k++) begin
            v[NUM_TAPS-k] = 1'b1;
            run(v);
        end

        // Random thermometers with bubbles, and fully random words
        for (int n = 0; n < 30; n++) begin
            v = '0;
            t = $urandom_range(0, NUM_TAPS);
            for (int i = 0; i < NUM_TAPS; i++) v[i] = (i < int'(t));
            for (int b = 0; b < 3; b++) v[$urandom_range(0, NUM_TAPS - 1)] ^= 1'b1;
            run(v);
            for (int i = 0; i < NUM_TAPS; i++) v[i] = $urandom_range(0, 1) != 0;
            run(v);
        end

        // Input change and go pulse mid-COUNT are ignored
        v = '0;
        for (int i = 0; i < 100; i++) v[i] = 1'b1;
        pulse_go(v);
        repeat (10) @(posedge clk);
        #1;
        v2 = '1;
        vec_s = v2;
        go_s  = 1'b1;
        @(posedge clk);
        #1;
        go_s  = 1'b0;
        vec_s = '0;
        wait_done();
        repeat (60) @(posedge clk);

        // Reset mid-COUNT discards the pending result; a later go completes
        v = '0;
        for (int i = 0; i < 200; i++) v[i] = 1'b1;
        pulse_go(v);
        repeat (20) @(posedge clk);
        do_reset();
        repeat (70) @(posedge clk);
        v = '0;
        for (int i = 0; i < 150; i++) v[i] = 1'b1;
        run(v);

        // go held for 100 cycles
        repeat (3) @(posedge clk);
        fr0 = n_fin_r;
        #1;
        v = '0;
        for (int i = 0; i < 77; i++) v[i] = 1'b1;
        vec_s = v;
        go_s  = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        go_s = 1'b0;
        repeat (130) @(posedge clk);
        check_val("hold_go_pulses", n_fin_r - fr0, HOLD_PULSES);

        // Every predicted result must have been delivered
        for (int k = 0; k < 200 && (q_r.size() != 0 || q_f.size() != 0); k++) @(posedge clk);
        check_val("pending_r", q_r.size(), 0);
        check_val("pending_f", q_f.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_tdc_decode
